mitm_forward_engine: RTL and testbench
======================================

Name: mitm_forward_engine

Overview:
- Sits on the MITM-logic side of the bus interface and drives its fake-send command port for one direction; instantiate once per direction (if0->if1, if1->if0).
- Captures each byte the real device sends (recv_new_data/real_recv_data) into a small FIFO and applies an optional match/replace substitution.
- Replays each byte on the opposite interface through the send_ready/send_start/send_done handshake.
- Holds the select and keep-alive lines so the controller keeps the fake path and bus session open.

Parameters:
- NUM_DATA_BITS, 8, data word width; must match the bus interface.
- FIFO_DEPTH, 4, capture FIFO entries; power of two, at least 2.
- MATCH_VALUE, 8'h00, received word that triggers substitution.
- REPLACE_VALUE, 8'hFF, word transmitted in place of MATCH_VALUE.
- DONE_TIMEOUT, 65535, sys_clk cycles to wait for send_done before aborting.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  forwarding enabled; 0 lets the controller pass real traffic.
- subst_en  in  1  apply MATCH_VALUE->REPLACE_VALUE substitution at capture.
- clear_flags  in  1  one-cycle pulse; clears overflow and timeout.
- recv_new_data  in  1  one-cycle pulse: real_recv_data is valid.
- real_recv_data  in  NUM_DATA_BITS  word received from the real device.
- send_ready  in  1  controller can accept a fake send.
- send_done  in  1  one-cycle pulse: fake send completed.
- fake_select  out  1  selects the fake path on the opposite interface.
- send_start  out  1  one-cycle start pulse.
- send_data  out  NUM_DATA_BITS  word to transmit; stable from send_start until send_done.
- keep_alive  out  1  holds the bus session (for example, SPI SS) while work is pending.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- timeout  out  1  sticky: send_done did not arrive within DONE_TIMEOUT.
- subst_count  out  16  count of substituted words; saturates at 16'hFFFF.

Behaviour:
Reset (rst low, async):
- All outputs are 0.
- FIFO is empty.
- FSM is in IDLE.
- Timeout counter is 0.

Capture:
- On a sys_clk edge with recv_new_data=1 and enable=1, write one word.
- The written word is REPLACE_VALUE when subst_en=1 and real_recv_data==MATCH_VALUE; otherwise it is real_recv_data.
- subst_count increments on each substitution.
- When enable=0, recv_new_data is ignored.

FIFO:
- Standard full/empty flags; pointers wrap modulo FIFO_DEPTH.
- A push when full drops the word and sets overflow, unless a pop occurs in the same cycle. In that case the push is accepted and overflow is not set.
- A simultaneous push and pop when empty is impossible: a pop needs non-empty in the previous cycle.

FSM states: IDLE, START, WAIT_DONE.
- IDLE -> START when FIFO is non-empty, send_ready=1 and enable=1. On this edge, pop the FIFO head into the send_data register.
- START: send_start=1 for exactly this cycle, then go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE -> IDLE on send_done=1.
- WAIT_DONE -> IDLE with timeout set when the counter reaches DONE_TIMEOUT-1. The popped word is discarded and is not retried.
- A send_done pulse seen outside WAIT_DONE is ignored.

Latency:
- A word captured at edge N with send_ready high gives send_start=1 in cycle N+2.
- Each further queued word starts no earlier than 2 cycles after the preceding send_done.

fake_select:
- Registered.
- Equals enable while in IDLE.
- Held high in START and WAIT_DONE even if enable falls, then drops on return to IDLE.

keep_alive:
- Registered.
- Equals fake_select AND (FIFO non-empty OR state != IDLE).

Flags:
- overflow and timeout clear only on clear_flags or reset.
- A set event coincident with clear_flags wins, so the flag stays 1.

Enable deasserted mid-transfer:
- The current word completes normally.
- Remaining FIFO contents are flushed on the first IDLE cycle with enable=0.

Decomposition:
- Shared package mitm_pkg holds:
  - FSM state localparams (IDLE=2'd0, START=2'd1, WAIT_DONE=2'd2);
  - the counter width constant (16);
  - a clog2-based pointer-width helper.
- Sub-module mitm_sync_fifo, parameterised by width and depth, with push/pop/full/empty/flush ports.
- The engine instantiates one mitm_sync_fifo and contains the FSM, substitution, flags and counters.

Test Plan:
- Reset mid-transfer: assert rst low during WAIT_DONE -> all outputs 0 immediately; FIFO empty after release; no send_start.
- Single forward: enable=1, send_ready=1, recv 8'hA5 -> send_start pulse 2 cycles later, send_data=8'hA5 held until send_done; keep_alive high from capture until return to IDLE.
- Substitution: subst_en=1, recv 8'h00, 8'h12, 8'h00 -> sent sequence 8'hFF, 8'h12, 8'hFF; subst_count=2.
- Overflow: FIFO_DEPTH=4, send_ready=0, recv 5 words 1..5 -> overflow=1; after send_ready=1, sent sequence 1,2,3,4; clear_flags clears overflow.
- Timeout: DONE_TIMEOUT=16, send_done never pulsed -> timeout=1 16 cycles after start; FSM returns to IDLE and sends the next queued word.
- Enable drop: 3 words queued, drop enable during the first send -> fake_select held until send_done; remaining 2 words flushed; no further send_start.

Source files
------------

// File: rtl/mitm_pkg.sv
// Shared definitions for the MITM forward engine: FSM encoding, counter width
// and the FIFO pointer-width helper.
package mitm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mitm_sync_fifo.sv
// Single-clock capture FIFO with occupancy count and synchronous flush.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module mitm_sync_fifo
  import mitm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [ptr_w(DEPTH):0]   count
);

  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mitm_forward_engine.sv
// One-direction MITM forwarder: captures words from the real device, optionally
// substitutes MATCH_VALUE, and replays them through the fake-send handshake.
module mitm_forward_engine
  import mitm_pkg::*;
#(
  parameter int                       NUM_DATA_BITS = 8,
  parameter int                       FIFO_DEPTH    = 4,
  parameter logic [NUM_DATA_BITS-1:0] MATCH_VALUE   = 8'h00,
  parameter logic [NUM_DATA_BITS-1:0] REPLACE_VALUE = 8'hFF,
  parameter int                       DONE_TIMEOUT  = 65535
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     subst_en,
  input  logic                     clear_flags,
  input  logic                     recv_new_data,
  input  logic [NUM_DATA_BITS-1:0] real_recv_data,
  input  logic                     send_ready,
  input  logic                     send_done,
  output logic                     fake_select,
  output logic                     send_start,
  output logic [NUM_DATA_BITS-1:0] send_data,
  output logic                     keep_alive,
  output logic                     overflow,
  output logic                     timeout,
  output logic [CNT_W-1:0]         subst_count
);

  localparam int PW = ptr_w(FIFO_DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t                   state, state_n;
  logic [CNT_W-1:0]         tmo_cnt;
  logic [NUM_DATA_BITS-1:0] wdata, head;
  logic [PW:0]              fifo_count, count_n;
  logic push_req, push, pop, flush, full, empty, subst_hit, tmo_hit, fs_n, ka_n;

  mitm_sync_fifo #(
    .WIDTH (NUM_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst),
    .flush (flush),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    push_req  = recv_new_data & enable;
    pop       = (state == IDLE) & ~empty & send_ready & enable;
    push      = push_req & (~full | pop);
    flush     = (state == IDLE) & ~enable;
    subst_hit = subst_en & (real_recv_data == MATCH_VALUE);
    wdata     = subst_hit ? REPLACE_VALUE : real_recv_data;
    tmo_hit   = (tmo_cnt == CNT_W'(DONE_TIMEOUT - 1));

    state_n = state;
    case (state)
      IDLE:      if (pop) state_n = START;
      START:     state_n = WAIT_DONE;
      WAIT_DONE: if (send_done || tmo_hit) state_n = IDLE;
      default:   state_n = IDLE;
    endcase

    // keep_alive is registered from next-cycle values so it tracks the
    // FIFO/FSM without a cycle of lag.
    if (flush) begin
      count_n = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_n = fifo_count + (PW+1)'(1);
        2'b01:   count_n = fifo_count - (PW+1)'(1);
        default: count_n = fifo_count;
      endcase
    end
    fs_n = (state_n == IDLE) ? enable : 1'b1;
    ka_n = fs_n & ((count_n != '0) | (state_n != IDLE));
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      fake_select <= 1'b0;
      send_start  <= 1'b0;
      send_data   <= '0;
      keep_alive  <= 1'b0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
      subst_count <= '0;
    end else begin
      state       <= state_n;
      fake_select <= fs_n;
      keep_alive  <= ka_n;
      send_start  <= pop;
      if (pop) send_data <= head;

      if (state == START)
        tmo_cnt <= '0;
      else if (state == WAIT_DONE && !send_done && !tmo_hit)
        tmo_cnt <= tmo_cnt + CNT_W'(1);

      // Set events take priority over a coincident clear.
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clear_flags)         overflow <= 1'b0;

      if (state == WAIT_DONE && !send_done && tmo_hit) timeout <= 1'b1;
      else if (clear_flags)                            timeout <= 1'b0;

      if (push && subst_hit) subst_count <= sat_inc(subst_count);
    end
  end

endmodule

// File: tb/tb_mitm_forward_engine.sv
// Directed bench for mitm_forward_engine (depth 4, timeout 16 cycles).
module tb_mitm_forward_engine;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        subst_en = 1'b0;
  logic        clear_flags = 1'b0;
  logic        recv_new_data = 1'b0;
  logic [7:0]  real_recv_data = 8'h00;
  logic        send_ready = 1'b0;
  logic        send_done = 1'b0;
  logic        fake_select;
  logic        send_start;
  logic [7:0]  send_data;
  logic        keep_alive;
  logic        overflow;
  logic        timeout;
  logic [15:0] subst_count;

  int n_cmp = 0;
  int n_fail = 0;

  mitm_forward_engine #(
    .NUM_DATA_BITS (8),
    .FIFO_DEPTH    (4),
    .MATCH_VALUE   (8'h00),
    .REPLACE_VALUE (8'hFF),
    .DONE_TIMEOUT  (16)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .enable         (enable),
    .subst_en       (subst_en),
    .clear_flags    (clear_flags),
    .recv_new_data  (recv_new_data),
    .real_recv_data (real_recv_data),
    .send_ready     (send_ready),
    .send_done      (send_done),
    .fake_select    (fake_select),
    .send_start     (send_start),
    .send_data      (send_data),
    .keep_alive     (keep_alive),
    .overflow       (overflow),
    .timeout        (timeout),
    .subst_count    (subst_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic push_word(input logic [7:0] d);
    recv_new_data  = 1'b1;
    real_recv_data = d;
    tick();
    recv_new_data  = 1'b0;
  endtask

  task automatic pulse_done();
    send_done = 1'b1;
    tick();
    send_done = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (send_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (fake_select !== 1'b0) begin n_fail++; $display("FAIL reset_fake_select: got %b want 0", fake_select); end
    n_cmp++; if (send_start !== 1'b0) begin n_fail++; $display("FAIL reset_send_start: got %b want 0", send_start); end
    n_cmp++; if (send_data !== 8'h00) begin n_fail++; $display("FAIL reset_send_data: got %h want 00", send_data); end
    n_cmp++; if (keep_alive !== 1'b0) begin n_fail++; $display("FAIL reset_keep_alive: got %b want 0", keep_alive); end
    n_cmp++; if ({overflow, timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {overflow, timeout}); end
    n_cmp++; if (subst_count !== 16'h0) begin n_fail++; $display("FAIL reset_subst_count: got %h want 0000", subst_count); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    enable = 1'b1;
    send_ready = 1'b1;
    tick();
    n_cmp++; if (fake_select !== 1'b1) begin n_fail++; $display("FAIL single_fake_select: got %b want 1", fake_select); end
    n_cmp++; if (keep_alive !== 1'b0) begin n_fail++; $display("FAIL single_ka_idle: got %b want 0", keep_alive); end
    push_word(8'hA5);
    n_cmp++; if (send_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b want 0", send_start); end
    n_cmp++; if (keep_alive !== 1'b1) begin n_fail++; $display("FAIL single_ka_capture: got %b want 1", keep_alive); end
    tick();
    n_cmp++; if (send_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", send_start); end
    n_cmp++; if (send_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", send_data); end
    tick();
    n_cmp++; if (send_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %b want 0", send_start); end
    tick();
    tick();
    n_cmp++; if (send_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold: got %h want a5", send_data); end
    n_cmp++; if (keep_alive !== 1'b1) begin n_fail++; $display("FAIL single_ka_wait: got %b want 1", keep_alive); end
    pulse_done();
    n_cmp++; if (keep_alive !== 1'b0) begin n_fail++; $display("FAIL single_ka_done: got %b want 0", keep_alive); end
    n_cmp++; if (fake_select !== 1'b1) begin n_fail++; $display("FAIL single_fs_done: got %b want 1", fake_select); end
  endtask

  task automatic test_subst();
    logic [7:0] in_words [3];
    logic [7:0] exp_words [3];
    bit ok;
    in_words  = '{8'h00, 8'h12, 8'h00};
    exp_words = '{8'hFF, 8'h12, 8'hFF};
    subst_en = 1'b1;
    send_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(in_words[i]);
    send_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_start(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL subst_start_%0d: got no send_start want pulse", i); end
      n_cmp++; if (send_data !== exp_words[i]) begin n_fail++; $display("FAIL subst_data_%0d: got %h want %h", i, send_data, exp_words[i]); end
      tick();
      pulse_done();
    end
    n_cmp++; if (subst_count !== 16'd2) begin n_fail++; $display("FAIL subst_count: got %0d want 2", subst_count); end
    subst_en = 1'b0;
  endtask

  task automatic test_overflow();
    bit ok;
    int starts;
    send_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
    push_word(8'd5);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    send_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_start(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovf_start_%0d: got no send_start want pulse", i); end
      n_cmp++; if (send_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_data_%0d: got %h want %h", i, send_data, 8'(i)); end
      tick();
      pulse_done();
    end
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      if (send_start === 1'b1) starts++;
      tick();
    end
    n_cmp++; if (starts != 0) begin n_fail++; $display("FAIL ovf_dropped_word: got %0d extra starts want 0", starts); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_timeout();
    bit ok;
    send_ready = 1'b0;
    push_word(8'h33);
    push_word(8'h44);
    send_ready = 1'b1;
    wait_start(ok);
    n_cmp++; if (!ok || send_data !== 8'h33) begin n_fail++; $display("FAIL tmo_first: got ok=%b data=%h want ok=1 data=33", ok, send_data); end
    // WAIT_DONE runs 16 cycles (count 0..15) and aborts on the 17th edge after start.
    for (int k = 1; k <= 16; k++) tick();
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", timeout); end
    tick();
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", timeout); end
    tick();
    n_cmp++; if (send_start !== 1'b1 || send_data !== 8'h44) begin n_fail++; $display("FAIL tmo_next: got start=%b data=%h want start=1 data=44", send_start, send_data); end
    tick();
    pulse_done();
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", timeout); end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", timeout); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int starts;
    send_ready = 1'b0;
    push_word(8'h51);
    push_word(8'h52);
    push_word(8'h53);
    send_ready = 1'b1;
    wait_start(ok);
    n_cmp++; if (!ok || send_data !== 8'h51) begin n_fail++; $display("FAIL drop_first: got ok=%b data=%h want ok=1 data=51", ok, send_data); end
    tick();
    enable = 1'b0;
    tick();
    tick();
    n_cmp++; if (fake_select !== 1'b1) begin n_fail++; $display("FAIL drop_fs_held: got %b want 1", fake_select); end
    n_cmp++; if (keep_alive !== 1'b1) begin n_fail++; $display("FAIL drop_ka_held: got %b want 1", keep_alive); end
    pulse_done();
    n_cmp++; if (fake_select !== 1'b0) begin n_fail++; $display("FAIL drop_fs_release: got %b want 0", fake_select); end
    n_cmp++; if (keep_alive !== 1'b0) begin n_fail++; $display("FAIL drop_ka_release: got %b want 0", keep_alive); end
    push_word(8'h99);
    tick();
    enable = 1'b1;
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (send_start === 1'b1) starts++;
    end
    n_cmp++; if (starts != 0) begin n_fail++; $display("FAIL drop_flushed: got %0d starts want 0", starts); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int starts;
    send_ready = 1'b0;
    push_word(8'h77);
    push_word(8'h78);
    send_ready = 1'b1;
    wait_start(ok);
    n_cmp++; if (!ok || send_data !== 8'h77) begin n_fail++; $display("FAIL rmid_first: got ok=%b data=%h want ok=1 data=77", ok, send_data); end
    tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({fake_select, send_start, keep_alive, overflow, timeout} !== 5'b0) begin n_fail++; $display("FAIL rmid_ctrl: got %b want 00000", {fake_select, send_start, keep_alive, overflow, timeout}); end
    n_cmp++; if (send_data !== 8'h00 || subst_count !== 16'h0) begin n_fail++; $display("FAIL rmid_data: got data=%h cnt=%h want 00/0000", send_data, subst_count); end
    @(negedge sys_clk);
    rst = 1'b1;
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (send_start === 1'b1) starts++;
    end
    n_cmp++; if (starts != 0) begin n_fail++; $display("FAIL rmid_no_start: got %0d starts want 0", starts); end
    n_cmp++; if (keep_alive !== 1'b0) begin n_fail++; $display("FAIL rmid_ka: got %b want 0", keep_alive); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_subst();
    test_overflow();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
